// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the memory interface unit between
// the instruction-fetch port and the load/store port. Address and store data
// are captured at grant, read data and a one-cycle done pulse are returned to
// the owner, and every transaction ends with a one-cycle DRAIN state.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort grants that never see
// mi_done within TIMEOUT cycles (owner gets done + err with data 8'hFF).
module mem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [7:0]        if_data,
    input  logic              ls_load,
    input  logic              ls_store,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [7:0]        ls_rdata,
    output logic              mi_load,
    output logic              mi_store,
    output logic [ADDR_W-1:0] mi_addr,
    output logic [DATA_W-1:0] mi_result,
    input  logic              mi_done,
    input  logic [7:0]        mi_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // last_gnt encoding: 0 = fetch port, 1 = data port
    localparam logic LAST_FETCH = 1'b0;
    localparam logic LAST_DATA  = 1'b1;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                last_gnt_r;
    logic                last_gnt_nxt_s;
    logic                if_gnt_r;
    logic                if_done_r;
    logic                if_done_nxt_s;
    logic [7:0]          if_data_r;
    logic [7:0]          if_data_nxt_s;
    logic                ls_gnt_r;
    logic                ls_done_r;
    logic                ls_done_nxt_s;
    logic [7:0]          ls_rdata_r;
    logic [7:0]          ls_rdata_nxt_s;
    logic                mi_load_r;
    logic                mi_load_nxt_s;
    logic                mi_store_r;
    logic                mi_store_nxt_s;
    logic [ADDR_W-1:0]   mi_addr_r;
    logic [ADDR_W-1:0]   mi_addr_nxt_s;
    logic [DATA_W-1:0]   mi_result_r;
    logic [DATA_W-1:0]   mi_result_nxt_s;
    logic                busy_r;
    logic                err_r;
    logic                err_nxt_s;
    logic                want_if_s;
    logic                want_ls_s;
    logic                pick_data_s;
    logic                timeout_hit_s;
    logic                finish_s;
    logic [7:0]          ret_data_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;

    // Watchdog fires on the edge where the counter would reach TIMEOUT
    always_comb begin
        timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    // Without the watchdog a grant waits for mi_done indefinitely
    always_comb begin
        timeout_hit_s = 1'b0;
    end
`endif

    // Request decode and round-robin choice between the two ports
    always_comb begin
        want_if_s   = if_req;
        want_ls_s   = ls_load | ls_store;
        pick_data_s = 1'b0;
        if (want_if_s && want_ls_s) begin
            pick_data_s = (last_gnt_r == LAST_FETCH);
        end else if (want_ls_s) begin
            pick_data_s = 1'b1;
        end else begin
            pick_data_s = 1'b0;
        end
    end

    // Completion decode: mi_done beats a simultaneous watchdog expiry
    always_comb begin
        finish_s   = mi_done | timeout_hit_s;
        ret_data_s = 8'hFF;
        if (mi_done) begin
            ret_data_s = mi_rdata;
        end else begin
            ret_data_s = 8'hFF;
        end
    end

    // Next-state and next-output logic for the arbitration FSM
    always_comb begin
        state_nxt_s     = state_r;
        last_gnt_nxt_s  = last_gnt_r;
        if_done_nxt_s   = 1'b0;
        ls_done_nxt_s   = 1'b0;
        err_nxt_s       = 1'b0;
        if_data_nxt_s   = if_data_r;
        ls_rdata_nxt_s  = ls_rdata_r;
        mi_load_nxt_s   = mi_load_r;
        mi_store_nxt_s  = mi_store_r;
        mi_addr_nxt_s   = mi_addr_r;
        mi_result_nxt_s = mi_result_r;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_nxt_s       = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_nxt_s = '0;
`endif
                if (want_if_s || want_ls_s) begin
                    if (pick_data_s) begin
                        // Store wins when both load and store are raised
                        state_nxt_s     = ST_DATA;
                        last_gnt_nxt_s  = LAST_DATA;
                        mi_addr_nxt_s   = ls_addr;
                        mi_result_nxt_s = ls_wdata;
                        mi_store_nxt_s  = ls_store;
                        mi_load_nxt_s   = ~ls_store;
                    end else begin
                        state_nxt_s     = ST_FETCH;
                        last_gnt_nxt_s  = LAST_FETCH;
                        mi_addr_nxt_s   = if_addr;
                        mi_store_nxt_s  = 1'b0;
                        mi_load_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (finish_s) begin
                    state_nxt_s    = ST_DRAIN;
                    mi_load_nxt_s  = 1'b0;
                    mi_store_nxt_s = 1'b0;
                    err_nxt_s      = ~mi_done;
                    if (state_r == ST_DATA) begin
                        ls_done_nxt_s  = 1'b1;
                        ls_rdata_nxt_s = ret_data_s;
                    end else begin
                        if_done_nxt_s  = 1'b1;
                        if_data_nxt_s  = ret_data_s;
                    end
                end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_nxt_s = cnt_r + CNT_W'(1);
`endif
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                mi_load_nxt_s  = 1'b0;
                mi_store_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            last_gnt_r  <= LAST_FETCH;
            if_gnt_r    <= 1'b0;
            if_done_r   <= 1'b0;
            if_data_r   <= 8'h00;
            ls_gnt_r    <= 1'b0;
            ls_done_r   <= 1'b0;
            ls_rdata_r  <= 8'h00;
            mi_load_r   <= 1'b0;
            mi_store_r  <= 1'b0;
            mi_addr_r   <= '0;
            mi_result_r <= '0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            last_gnt_r  <= last_gnt_nxt_s;
            if_gnt_r    <= (state_nxt_s == ST_FETCH);
            if_done_r   <= if_done_nxt_s;
            if_data_r   <= if_data_nxt_s;
            ls_gnt_r    <= (state_nxt_s == ST_DATA);
            ls_done_r   <= ls_done_nxt_s;
            ls_rdata_r  <= ls_rdata_nxt_s;
            mi_load_r   <= mi_load_nxt_s;
            mi_store_r  <= mi_store_nxt_s;
            mi_addr_r   <= mi_addr_nxt_s;
            mi_result_r <= mi_result_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            err_r       <= err_nxt_s;
        end
    end

    assign if_gnt    = if_gnt_r;
    assign if_done   = if_done_r;
    assign if_data   = if_data_r;
    assign ls_gnt    = ls_gnt_r;
    assign ls_done   = ls_done_r;
    assign ls_rdata  = ls_rdata_r;
    assign mi_load   = mi_load_r;
    assign mi_store  = mi_store_r;
    assign mi_addr   = mi_addr_r;
    assign mi_result = mi_result_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule
